// File: rtl/mips_data_mem_if.sv
// rtl/mips_data_mem_if.sv - load/store bus between the mips core and its data memory
//
// Purpose: groups the request/response handshake of the data-memory port.
// Signals:
//   req        core -> mem  request strobe
//   data_op    core -> mem  1 = store, 0 = load
//   data_addr  core -> mem  byte address
//   byte_en    core -> mem  lane enables (bit i = bits [8i+7:8i])
//   write_val  core -> mem  lane-aligned store data
//   read_val   mem -> core  load data, held until the next load completes
//   busy       mem -> core  request in flight, new req ignored
//   ready      mem -> core  single-cycle completion pulse
//   misalign   mem -> core  qualifies ready: misaligned access
//   fault      mem -> core  qualifies ready: out-of-range access
interface mips_data_mem_if;
  logic        req;
  logic        data_op;
  logic [31:0] data_addr;
  logic [3:0]  byte_en;
  logic [31:0] write_val;
  logic [31:0] read_val;
  logic        busy;
  logic        ready;
  logic        misalign;
  logic        fault;

  modport master (
    output req, data_op, data_addr, byte_en, write_val,
    input  read_val, busy, ready, misalign, fault
  );

  modport slave (
    input  req, data_op, data_addr, byte_en, write_val,
    output read_val, busy, ready, misalign, fault
  );
endinterface

// File: rtl/mips_data_mem.sv
// rtl/mips_data_mem.sv - word-organised data RAM with byte enables and wait states
//
// Purpose: data-memory stage behind the mips core load/store port. One access
// in flight at a time; LATENCY wait cycles between acceptance and the ready
// pulse. The RAM is read/written at the edge that enters the response state.
// Ports:
//   clk    clock, all state on the rising edge
//   reset  synchronous, active-high
//   bus    mips_data_mem_if.slave (req/data_op/data_addr/byte_en/write_val in,
//          read_val/busy/ready/misalign/fault out)
// Optional feature macro: MEM_RANGE_CHECK_EN (out-of-range accesses fault
// instead of aliasing into the RAM).
module mips_data_mem #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input logic           clk,
  input logic           reset,
  mips_data_mem_if.slave bus
);

  localparam int         DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY > 0 ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] read_val_q, read_val_d;
  logic        misalign_q, misalign_d;
  logic        fault_q, fault_d;

  logic [31:0] mem [DEPTH];

  // Access operands: straight from the bus when the access happens on the
  // acceptance edge (LATENCY = 0), otherwise from the captured registers.
  logic                  a_op;
  logic [31:0]           a_addr;
  logic [3:0]            a_be;
  logic [31:0]           a_wdata;
  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  mis_c;
  logic                  oor_c;
  logic                  accept;
  logic                  do_access;
  logic                  wr_en;

  always_comb begin
    a_op    = (state_q == S_WAIT) ? op_q    : bus.data_op;
    a_addr  = (state_q == S_WAIT) ? addr_q  : bus.data_addr;
    a_be    = (state_q == S_WAIT) ? be_q    : bus.byte_en;
    a_wdata = (state_q == S_WAIT) ? wdata_q : bus.write_val;
    offset  = a_addr - BASE_ADDR;
    idx     = offset[ADDR_WIDTH+1:2];
    mis_c   = ((a_be == 4'b1111) && (offset[1:0] != 2'b00)) ||
              (((a_be == 4'b0011) || (a_be == 4'b1100)) && offset[0]);
  end

`ifdef MEM_RANGE_CHECK_EN
  assign oor_c = (a_addr < BASE_ADDR) || ((offset >> (ADDR_WIDTH + 2)) != 32'd0);
`else
  // Index wraps modulo depth; upper offset bits are intentionally dropped.
  logic unused_offset_hi;
  assign unused_offset_hi = ^offset[31:ADDR_WIDTH+2];
  assign oor_c = 1'b0;
`endif

  assign accept = bus.req && (state_q != S_WAIT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    do_access = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          op_d    = bus.data_op;
          addr_d  = bus.data_addr;
          be_d    = bus.byte_en;
          wdata_d = bus.write_val;
          if (LATENCY == 0) begin
            state_d   = S_RESP;
            do_access = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = S_RESP;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fault wins over misalign; either suppresses the RAM access.
  assign wr_en = do_access && a_op && !mis_c && !oor_c;

  always_comb begin
    read_val_d = read_val_q;
    if (do_access) begin
      if (mis_c || oor_c) read_val_d = 32'h0;
      else if (!a_op)     read_val_d = mem[idx];
    end
    misalign_d = do_access && mis_c && !oor_c;
    fault_d    = do_access && oor_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      op_q       <= 1'b0;
      addr_q     <= 32'h0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      read_val_q <= 32'h0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      read_val_q <= read_val_d;
      misalign_q <= misalign_d;
      fault_q    <= fault_d;
    end
  end

  // RAM is not cleared by reset; a store pending at reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (a_be[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  assign bus.read_val = read_val_q;
  assign bus.busy     = (state_q == S_WAIT);
  assign bus.ready    = (state_q == S_RESP);
  assign bus.misalign = misalign_q && (state_q == S_RESP);
  assign bus.fault    = fault_q && (state_q == S_RESP);

endmodule

// File: tb/tb_mips_data_mem.sv
// tb/tb_mips_data_mem.sv - directed self-checking bench for mips_data_mem
module tb_mips_data_mem;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Shared stimulus; req is steered to the instance selected by sel.
  int          sel = 2;
  logic        t_req = 1'b0;
  logic        t_op = 1'b0;
  logic [31:0] t_addr = 32'h0;
  logic [3:0]  t_be = 4'h0;
  logic [31:0] t_wd = 32'h0;

  mips_data_mem_if if2();
  mips_data_mem_if if0();
  mips_data_mem_if if3();

  assign if2.req = t_req && (sel == 2);
  assign if0.req = t_req && (sel == 0);
  assign if3.req = t_req && (sel == 3);
  assign if2.data_op = t_op;  assign if2.data_addr = t_addr;
  assign if2.byte_en = t_be;  assign if2.write_val = t_wd;
  assign if0.data_op = t_op;  assign if0.data_addr = t_addr;
  assign if0.byte_en = t_be;  assign if0.write_val = t_wd;
  assign if3.data_op = t_op;  assign if3.data_addr = t_addr;
  assign if3.byte_en = t_be;  assign if3.write_val = t_wd;

  mips_data_mem #(.ADDR_WIDTH(10), .LATENCY(2), .BASE_ADDR(32'h0)) u2 (
    .clk(clk), .reset(reset), .bus(if2));
  mips_data_mem #(.ADDR_WIDTH(4), .LATENCY(0), .BASE_ADDR(32'h0)) u0 (
    .clk(clk), .reset(reset), .bus(if0));
  mips_data_mem #(.ADDR_WIDTH(10), .LATENCY(3), .BASE_ADDR(32'h0)) u3 (
    .clk(clk), .reset(reset), .bus(if3));

  logic        o_ready, o_busy, o_mis, o_flt;
  logic [31:0] o_rv;
  always_comb begin
    o_ready = if2.ready; o_busy = if2.busy; o_mis = if2.misalign;
    o_flt = if2.fault; o_rv = if2.read_val;
    if (sel == 0) begin
      o_ready = if0.ready; o_busy = if0.busy; o_mis = if0.misalign;
      o_flt = if0.fault; o_rv = if0.read_val;
    end else if (sel == 3) begin
      o_ready = if3.ready; o_busy = if3.busy; o_mis = if3.misalign;
      o_flt = if3.fault; o_rv = if3.read_val;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts at posedge+1 with the selected DUT idle; returns at posedge+1
  // one cycle after the ready pulse.
  task automatic xfer(input int s, input logic op, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd,
                      output logic [31:0] rv, output logic mis,
                      output logic flt, output int lat);
    sel = s; t_op = op; t_addr = addr; t_be = be; t_wd = wd; t_req = 1'b1;
    tick();
    t_req = 1'b0;
    lat = 0;
    while (!o_ready && lat < 40) begin
      tick();
      lat++;
    end
    if (!o_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_timeout: got no ready after %0d cycles", lat);
    end
    rv = o_rv; mis = o_mis; flt = o_flt;
    tick();
  endtask

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        chk_rv;
    logic [31:0] exp_rv;
    logic        exp_mis;
  } vec_t;

  vec_t        vt [18];
  logic [31:0] w [4];
  logic [31:0] rv;
  logic        mis, flt;
  int          lat;
  int          nready;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h10, 4'b1111, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h20, 4'b1111, 32'h11223344, 1'b0, 32'h0,        1'b0};
    vt[3]  = '{1'b1, 32'h20, 4'b0100, 32'h00AA0000, 1'b0, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 32'h20, 4'b1111, 32'h0,        1'b1, 32'h11AA3344, 1'b0};
    vt[5]  = '{1'b0, 32'h22, 4'b1111, 32'h0,        1'b1, 32'h0,        1'b1};
    vt[6]  = '{1'b1, 32'h22, 4'b1111, 32'h55667788, 1'b0, 32'h0,        1'b1};
    vt[7]  = '{1'b0, 32'h20, 4'b1111, 32'h0,        1'b1, 32'h11AA3344, 1'b0};
    vt[8]  = '{1'b1, 32'h23, 4'b1000, 32'hCC000000, 1'b0, 32'h0,        1'b0};
    vt[9]  = '{1'b0, 32'h20, 4'b1111, 32'h0,        1'b1, 32'hCCAA3344, 1'b0};
    vt[10] = '{1'b0, 32'h21, 4'b0011, 32'h0,        1'b1, 32'h0,        1'b1};
    vt[11] = '{1'b1, 32'h22, 4'b1100, 32'h99880000, 1'b0, 32'h0,        1'b0};
    vt[12] = '{1'b0, 32'h20, 4'b0000, 32'h0,        1'b1, 32'h99883344, 1'b0};
    vt[13] = '{1'b1, 32'h24, 4'b1111, 32'h00000000, 1'b0, 32'h0,        1'b0};
    vt[14] = '{1'b1, 32'h24, 4'b0000, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0};
    vt[15] = '{1'b0, 32'h24, 4'b1111, 32'h0,        1'b1, 32'h00000000, 1'b0};
    vt[16] = '{1'b0, 32'h25, 4'b1100, 32'h0,        1'b1, 32'h0,        1'b1};
    vt[17] = '{1'b0, 32'h22, 4'b0011, 32'h0,        1'b1, 32'h99883344, 1'b0};
    w[0] = 32'h0BADF00D; w[1] = 32'h13579BDF; w[2] = 32'h2468ACE0; w[3] = 32'hCAFE0001;

    // Reset values
    repeat (3) tick();
    sel = 2;
    check("rst_busy", {31'h0, o_busy}, 32'h0);
    check("rst_ready", {31'h0, o_ready}, 32'h0);
    check("rst_misalign", {31'h0, o_mis}, 32'h0);
    check("rst_fault", {31'h0, o_flt}, 32'h0);
    check("rst_read_val", o_rv, 32'h0);
    reset = 1'b0;
    tick();

    // Cycle-exact handshake at LATENCY=2
    sel = 2; t_op = 1'b1; t_addr = 32'h10; t_be = 4'hF; t_wd = 32'hDEADBEEF; t_req = 1'b1;
    tick();
    t_req = 1'b0;
    check("l2_busy_k", {31'h0, o_busy}, 32'h1);
    check("l2_ready_k", {31'h0, o_ready}, 32'h0);
    tick();
    check("l2_busy_k1", {31'h0, o_busy}, 32'h1);
    check("l2_ready_k1", {31'h0, o_ready}, 32'h0);
    tick();
    check("l2_busy_k2", {31'h0, o_busy}, 32'h0);
    check("l2_ready_k2", {31'h0, o_ready}, 32'h1);
    check("l2_mis_k2", {31'h0, o_mis}, 32'h0);
    tick();
    check("l2_ready_k3", {31'h0, o_ready}, 32'h0);

    // Table-driven accesses on the LATENCY=2 instance
    for (int i = 0; i < 18; i++) begin
      xfer(2, vt[i].op, vt[i].addr, vt[i].be, vt[i].wd, rv, mis, flt, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d_misalign", i), {31'h0, mis}, {31'h0, vt[i].exp_mis});
      check($sformatf("vec%0d_fault", i), {31'h0, flt}, 32'h0);
      if (vt[i].chk_rv) check($sformatf("vec%0d_read_val", i), rv, vt[i].exp_rv);
    end

    // LATENCY=0 back-to-back loads with req held high
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b1, 32'(4 * i), 4'hF, w[i], rv, mis, flt, lat);
      check($sformatf("l0_store%0d_latency", i), 32'(lat), 32'd0);
    end
    sel = 0; t_op = 1'b0; t_be = 4'hF; t_addr = 32'h0; t_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("b2b_ready%0d", i), {31'h0, o_ready}, 32'h1);
      check($sformatf("b2b_read_val%0d", i), o_rv, w[i]);
      if (i == 3) t_req = 1'b0;
      else t_addr = 32'(4 * (i + 1));
    end
    tick();
    check("b2b_ready_end", {31'h0, o_ready}, 32'h0);

    // Out-of-range addresses on the 16-word instance
    xfer(0, 1'b0, 32'h40, 4'hF, 32'h0, rv, mis, flt, lat);
`ifdef MEM_RANGE_CHECK_EN
    check("oor_fault", {31'h0, flt}, 32'h1);
    check("oor_read_val", rv, 32'h0);
    check("oor_misalign", {31'h0, mis}, 32'h0);
`else
    check("alias_fault", {31'h0, flt}, 32'h0);
    check("alias_read_val", rv, w[0]);
    check("alias_misalign", {31'h0, mis}, 32'h0);
`endif
    xfer(0, 1'b0, 32'h42, 4'hF, 32'h0, rv, mis, flt, lat);
`ifdef MEM_RANGE_CHECK_EN
    check("oor_mis_fault", {31'h0, flt}, 32'h1);
    check("oor_mis_misalign", {31'h0, mis}, 32'h0);
`else
    check("alias_mis_fault", {31'h0, flt}, 32'h0);
    check("alias_mis_misalign", {31'h0, mis}, 32'h1);
`endif
    check("oor_mis_read_val", rv, 32'h0);

    // LATENCY=3: reset abandons a pending store
    xfer(3, 1'b1, 32'h30, 4'hF, 32'h12345678, rv, mis, flt, lat);
    check("l3_latency", 32'(lat), 32'd3);
    xfer(3, 1'b0, 32'h30, 4'hF, 32'h0, rv, mis, flt, lat);
    check("l3_load_before", rv, 32'h12345678);
    sel = 3; t_op = 1'b1; t_addr = 32'h30; t_be = 4'hF; t_wd = 32'hFFFF0000; t_req = 1'b1;
    tick();
    t_req = 1'b0;
    check("l3_busy_before_rst", {31'h0, o_busy}, 32'h1);
    reset = 1'b1;
    tick();
    check("rst_mid_busy", {31'h0, o_busy}, 32'h0);
    check("rst_mid_ready", {31'h0, o_ready}, 32'h0);
    check("rst_mid_read_val", o_rv, 32'h0);
    reset = 1'b0;
    tick();
    xfer(3, 1'b0, 32'h30, 4'hF, 32'h0, rv, mis, flt, lat);
    check("rst_mid_old_value", rv, 32'h12345678);

    // req pulsed while busy is not queued
    sel = 3; t_op = 1'b0; t_addr = 32'h30; t_be = 4'hF; t_req = 1'b1;
    tick();
    t_addr = 32'h34; t_req = 1'b1;
    tick();
    t_req = 1'b0;
    nready = 0;
    rv = 32'h0;
    for (int j = 0; j < 10; j++) begin
      if (o_ready) begin
        nready++;
        rv = o_rv;
      end
      tick();
    end
    check("busy_req_ready_count", 32'(nready), 32'd1);
    check("busy_req_read_val", rv, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
